// File: rtl/booth_mult_seq.sv
// Sequential signed 8x8 -> 16 radix-2 Booth multiplier.
// One add/sub plus arithmetic shift per clock, single-cycle done pulse.
module booth_mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [8:0]  a;
    logic [8:0]  m;
    logic [7:0]  q;
    logic        q_1;
    logic [3:0]  cnt;
    logic [8:0]  a_sum;
    logic [8:0]  a_nx;
    logic [7:0]  q_nx;
    logic        last;

    assign last = (cnt == 4'd7);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Subtract step adds the 9-bit two's complement of M, so -(-128) fits.
    always_comb begin
        a_sum = a;
        unique case ({q[0], q_1})
            2'b01:   a_sum = a + m;
            2'b10:   a_sum = a + (~m + 9'd1);
            default: a_sum = a;
        endcase
    end

    assign a_nx = {a_sum[8], a_sum[8:1]};
    assign q_nx = {a_sum[0], q[7:1]};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m   <= {multiplicand[7], multiplicand};
                        q   <= multiplier;
                        a   <= '0;
                        q_1 <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    q_1 <= q[0];
                    cnt <= cnt + 4'd1;
                    if (last) product <= {a_nx[7:0], q_nx};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq.
// Exact-latency checks of busy/done/product around each multiply.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_tests;
    int n_fail;

    booth_mult_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue at the next negedge; returns #1 after the done edge.
    // poke>0 pulses start with other operands during that RUN cycle.
    task automatic mul(input string tag, input logic [7:0] mv,
                       input logic [7:0] qv, input logic [15:0] exp,
                       input int poke);
        @(negedge clk);
        multiplicand = mv;
        multiplier   = qv;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy0"}, 16'(busy), 16'd1);
        chk({tag, ".done0"}, 16'(done), 16'd0);
        for (int k = 1; k <= 7; k++) begin
            if (k == poke) begin
                @(negedge clk);
                start        = 1'b1;
                multiplicand = 8'd1;
                multiplier   = 8'd1;
            end
            @(posedge clk);
            #1;
            start        = 1'b0;
            multiplicand = 8'h55;
            multiplier   = 8'hAA;
            chk({tag, ".busy"}, 16'(busy), 16'd1);
            chk({tag, ".done"}, 16'(done), 16'd0);
        end
        @(posedge clk);
        #1;
        chk({tag, ".done9"}, 16'(done), 16'd1);
        chk({tag, ".busy9"}, 16'(busy), 16'd0);
        chk({tag, ".prod"}, product, exp);
    endtask

    task automatic idle_chk(input string tag, input logic [15:0] hold);
        @(posedge clk);
        #1;
        chk({tag, ".done_drop"}, 16'(done), 16'd0);
        chk({tag, ".busy_idle"}, 16'(busy), 16'd0);
        chk({tag, ".prod_hold"}, product, hold);
    endtask

    logic signed [7:0]  sm;
    logic signed [7:0]  sq;
    logic signed [15:0] se;
    logic [7:0]         corner [5];

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        corner[0] = 8'h80;
        corner[1] = 8'hFF;
        corner[2] = 8'h00;
        corner[3] = 8'h01;
        corner[4] = 8'h7F;

        #12;
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.done", 16'(done), 16'd0);
        chk("rst.prod", product, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        mul("7x3", 8'd7, 8'd3, 16'h0015, 0);
        idle_chk("7x3", 16'h0015);
        mul("m5x3", 8'hFB, 8'd3, 16'hFFF1, 0);
        idle_chk("m5x3", 16'hFFF1);
        mul("3xm5", 8'd3, 8'hFB, 16'hFFF1, 0);
        mul("m128sq", 8'h80, 8'h80, 16'h4000, 0);
        mul("127xm128", 8'h7F, 8'h80, 16'hC080, 0);
        mul("0xA5", 8'h00, 8'hA5, 16'h0000, 0);
        idle_chk("0xA5", 16'h0000);

        mul("6x7ign", 8'd6, 8'd7, 16'h002A, 4);
        mul("b2b_m2", 8'hFE, 8'hFE, 16'h0004, 0);
        idle_chk("b2b_m2", 16'h0004);

        // Async reset between edges mid-operation.
        @(negedge clk);
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.busy", 16'(busy), 16'd0);
        chk("arst.done", 16'(done), 16'd0);
        chk("arst.prod", product, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            chk("arst.nodone", 16'(done), 16'd0);
            chk("arst.nobusy", 16'(busy), 16'd0);
        end
        mul("post_rst", 8'd12, 8'd11, 16'h0084, 0);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                sm = corner[i];
                sq = corner[j];
                se = sm * sq;
                mul("corner", corner[i], corner[j], se, 0);
            end
        end

        for (int i = 0; i < 30; i++) begin
            sm = 8'($urandom_range(255));
            sq = 8'($urandom_range(255));
            se = sm * sq;
            mul("rand", sm, sq, se, 0);
        end
        idle_chk("final", se);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
